// File: rtl/div_sched.sv
// Round-robin scheduler sharing one fixed-latency external divider among NREQ
// requesters, with a credit-limited result FIFO and divide-by-zero/overflow flags.
module div_sched #(
  parameter int K      = 32,
  parameter int NREQ   = 4,
  parameter int LAT    = 2,
  parameter int FDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*(K+32)-1:0]  req_x,
  input  logic [NREQ*K-1:0]       req_d,
  output logic [K+31:0]           div_x,
  output logic [K-1:0]            div_d,
  input  logic [K-1:0]            div_q,
  input  logic [K-1:0]            div_r,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [K-1:0]            rsp_q,
  output logic [K-1:0]            rsp_r,
  output logic                    rsp_dz,
  output logic                    rsp_ovf
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(FDEPTH);
  localparam int CW  = $clog2(FDEPTH + 1) + 1;
  localparam int EW  = IDW + 2*K + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FDEPTH);

  logic [IDW-1:0] r_last;
  logic [CW-1:0]  r_inflight;
  logic [CW-1:0]  r_count;
  logic [LAT-1:0] r_tv;
  logic [LAT-1:0] r_tdz;
  logic [LAT-1:0] r_tovf;
  logic [IDW-1:0] r_tid [LAT];
  logic [K-1:0]   r_txl [LAT];
  logic [EW-1:0]  r_mem [FDEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;

  logic           w_hi_found;
  logic           w_lo_found;
  logic [IDW-1:0] w_hi_idx;
  logic [IDW-1:0] w_lo_idx;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [CW-1:0]  w_credits;
  logic           w_issue;
  logic           w_dz;
  logic           w_ovf;
  logic           w_retire;
  logic           w_pop;
  logic [K-1:0]   w_rq;
  logic [K-1:0]   w_rr;
  logic [EW-1:0]  w_entry;
  logic [EW-1:0]  w_head;

  // Round robin: first requester above last_grant wins, else first at/below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (IDW'(i) > r_last) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = IDW'(i);
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDW'(i);
        end
      end
    end
  end

  assign w_found   = w_hi_found | w_lo_found;
  assign w_win     = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_credits = r_count + r_inflight;
  assign w_issue   = !rst && w_found && (w_credits < DEPTH_C);

  always_comb begin
    req_ready = '0;
    div_x     = '0;
    div_d     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_issue && (w_win == IDW'(i))) begin
        req_ready[i] = 1'b1;
        div_x        = req_x[i*(K+32) +: (K+32)];
        div_d        = req_d[i*K +: K];
      end
    end
  end

  assign w_dz  = (div_d == '0);
  assign w_ovf = !w_dz && (div_x[K+31:32] >= div_d);

  assign w_retire = r_tv[LAT-1];
  assign w_pop    = rsp_valid && rsp_ready;

  always_comb begin
    w_rq = div_q;
    w_rr = div_r;
    if (r_tdz[LAT-1]) begin
      w_rq = '1;
      w_rr = r_txl[LAT-1];
    end
  end

  assign w_entry = {r_tid[LAT-1], w_rq, w_rr, r_tdz[LAT-1], r_tovf[LAT-1]};

  // Tag pipeline mirrors the divider latency; the low dividend bits ride along for the dz remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tv   <= '0;
      r_tdz  <= '0;
      r_tovf <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        r_tid[s] <= '0;
        r_txl[s] <= '0;
      end
    end else begin
      r_tv[0]   <= w_issue;
      r_tdz[0]  <= w_dz;
      r_tovf[0] <= w_ovf;
      r_tid[0]  <= w_win;
      r_txl[0]  <= div_x[K-1:0];
      for (int unsigned s = 1; s < LAT; s++) begin
        r_tv[s]   <= r_tv[s-1];
        r_tdz[s]  <= r_tdz[s-1];
        r_tovf[s] <= r_tovf[s-1];
        r_tid[s]  <= r_tid[s-1];
        r_txl[s]  <= r_txl[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= IDW'(NREQ - 1);
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_issue) begin
        r_last <= w_win;
      end
      case ({w_issue, w_retire})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_retire, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_retire) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_retire) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign rsp_valid = (r_count != '0);

  always_comb begin
    rsp_id  = '0;
    rsp_q   = '0;
    rsp_r   = '0;
    rsp_dz  = 1'b0;
    rsp_ovf = 1'b0;
    if (rsp_valid) begin
      {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf} = w_head;
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: behavioural fixed-latency divider, arbitration/credit
// reference model with a response scoreboard, vector table and corner sequences.
module tb_div_sched;

  localparam int K      = 32;
  localparam int NREQ   = 4;
  localparam int LAT    = 2;
  localparam int FDEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*(K+32)-1:0] req_x;
  logic [NREQ*K-1:0]      req_d;
  logic [K+31:0]          div_x;
  logic [K-1:0]           div_d;
  logic [K-1:0]           div_q;
  logic [K-1:0]           div_r;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [K-1:0]           rsp_q;
  logic [K-1:0]           rsp_r;
  logic                   rsp_dz;
  logic                   rsp_ovf;

  always #5 clk = ~clk;

  div_sched #(.K(K), .NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_d(req_d),
    .div_x(div_x), .div_d(div_d),
    .div_q(div_q), .div_r(div_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf)
  );

  // External divider: operands captured on the issue edge, result valid LAT cycles later.
  logic [95:0] dpipe [LAT];
  logic [63:0] dv_x, dv_q, dv_r;
  logic [31:0] dv_d;

  always @(posedge clk) begin
    dpipe[0] <= {div_x, div_d};
    for (int s = 1; s < LAT; s++) dpipe[s] <= dpipe[s-1];
  end

  always_comb begin
    dv_x = dpipe[LAT-1][95:32];
    dv_d = dpipe[LAT-1][31:0];
    dv_q = '0;
    dv_r = '0;
    if (dv_d != 0) begin
      dv_q = dv_x / {32'b0, dv_d};
      dv_r = dv_x % {32'b0, dv_d};
    end
    div_q = dv_q[31:0];
    div_r = dv_r[31:0];
  end

  typedef struct {
    logic [1:0]  id;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
  } rsp_t;

  typedef struct {
    int unsigned id;
    logic [63:0] x;
    logic [31:0] d;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    logic        eovf;
  } vec_t;

  rsp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_out;
  int unsigned m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t model(input int unsigned id, input logic [63:0] x, input logic [31:0] d);
    rsp_t e;
    logic [63:0] t;
    e.id  = 2'(id);
    e.dz  = (d == 0);
    e.ovf = !e.dz && (x[63:32] >= d);
    if (e.dz) begin
      e.q = '1;
      e.r = x[31:0];
    end else begin
      t   = x / {32'b0, d};
      e.q = t[31:0];
      t   = x % {32'b0, d};
      e.r = t[31:0];
    end
    return e;
  endfunction

  // Reference arbiter tracks outstanding work as issued-minus-popped.
  always @(negedge clk) begin : mon
    rsp_t        e;
    logic [3:0]  exp_rdy;
    int unsigned w;
    int unsigned idx;
    bit          f;
    if (rst) begin
      sb.delete();
      m_out  = 0;
      m_last = NREQ - 1;
    end else begin
      f = 1'b0;
      w = 0;
      for (int unsigned o = 1; o <= NREQ; o++) begin
        idx = (m_last + o) % NREQ;
        if (!f && req_valid[idx]) begin
          f = 1'b1;
          w = idx;
        end
      end
      exp_rdy = (f && m_out < FDEPTH) ? 4'(1 << w) : 4'b0;
      check("grant", 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy != 0) begin
        sb.push_back(model(w, req_x[w*64 +: 64], req_d[w*32 +: 32]));
        m_last = w;
        m_out++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: response id=%0d q=%0h with nothing expected", rsp_id, rsp_q);
        end else begin
          e = sb.pop_front();
          check("sb_id", 64'(rsp_id), 64'(e.id));
          check("sb_q", 64'(rsp_q), 64'(e.q));
          check("sb_r", 64'(rsp_r), 64'(e.r));
          check("sb_dz", 64'(rsp_dz), 64'(e.dz));
          check("sb_ovf", 64'(rsp_ovf), 64'(e.ovf));
        end
        m_out--;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_div_x"}, div_x, 64'd0);
    check({tag, "_div_d"}, 64'(div_d), 64'd0);
    check({tag, "_rsp_fields"}, 64'({rsp_id, rsp_q, rsp_dz, rsp_ovf}), 64'd0);
    check({tag, "_rsp_r"}, 64'(rsp_r), 64'd0);
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue_one(input int unsigned id, input logic [63:0] x, input logic [31:0] d);
    bit ok;
    req_x[id*64 +: 64] = x;
    req_d[id*32 +: 32] = d;
    req_valid[id]      = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("issue_ready", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) break;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    int   cnt;

    vecs[0] = '{0, 64'd100,                 32'd7,       32'd14,         32'd2,      1'b0, 1'b0};
    vecs[1] = '{1, 64'd1000,                32'd10,      32'd100,        32'd0,      1'b0, 1'b0};
    vecs[2] = '{2, 64'h1_0000_0005,         32'd0,       32'hFFFF_FFFF,  32'd5,      1'b1, 1'b0};
    vecs[3] = '{3, 64'h5_0000_0000,         32'd3,       32'hAAAA_AAAA,  32'd2,      1'b0, 1'b1};
    vecs[4] = '{2, 64'h0000_FFFF_FFFF_FFFF, 32'h1_0000,  32'hFFFF_FFFF,  32'hFFFF,   1'b0, 1'b0};
    vecs[5] = '{3, 64'h7_0000_0000,         32'd7,       32'd0,          32'd0,      1'b0, 1'b1};
    vecs[6] = '{0, 64'd5,                   32'd1,       32'd5,          32'd0,      1'b0, 1'b0};
    vecs[7] = '{1, 64'd0,                   32'd0,       32'hFFFF_FFFF,  32'd0,      1'b1, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_d     = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    check_outputs_zero("por");
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;

    rsp_ready = 1'b1;
    foreach (vecs[v]) begin
      issue_one(vecs[v].id, vecs[v].x, vecs[v].d);
      wait_rsp(lat);
      check("vec_latency", 64'(lat), 64'(LAT));
      check("vec_id", 64'(rsp_id), 64'(vecs[v].id));
      check("vec_q", 64'(rsp_q), 64'(vecs[v].eq));
      check("vec_r", 64'(rsp_r), 64'(vecs[v].er));
      check("vec_dz", 64'(rsp_dz), 64'(vecs[v].edz));
      check("vec_ovf", 64'(rsp_ovf), 64'(vecs[v].eovf));
      @(posedge clk); #1;
    end

    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*64 +: 64] = 64'(1000 * (i + 1) + i);
      req_d[i*32 +: 32] = 32'(i + 3);
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int n = 0; n < 12; n++) begin
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << (n % 4);
      @(negedge clk);
      check("rr_order", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk); #1;
    end
    drain();

    do_reset();
    req_valid = '1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (|req_ready) cnt++;
      @(posedge clk); #1;
    end
    check("credit_issues", 64'(cnt), 64'(FDEPTH));
    @(negedge clk);
    check("credit_block", 64'(req_ready), 64'd0);
    check("credit_full_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        if (|req_ready) cnt++;
        @(posedge clk); #1;
      end
      check("credit_refill", 64'(cnt), 64'd1);
    end
    drain();

    // Reset with A buffered in the FIFO and B, C still in the tag pipeline.
    do_reset();
    issue_one(0, 64'd50, 32'd6);
    @(posedge clk); #1;
    issue_one(1, 64'd60, 32'd7);
    issue_one(2, 64'd70, 32'd8);
    @(negedge clk);
    check("prerst_buffered", 64'(rsp_valid), 64'd1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("postrst_quiet", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue_one(3, 64'd77, 32'd5);
    wait_rsp(lat);
    check("postrst_latency", 64'(lat), 64'(LAT));
    check("postrst_id", 64'(rsp_id), 64'd3);
    check("postrst_q", 64'(rsp_q), 64'd15);
    check("postrst_r", 64'(rsp_r), 64'd2);
    @(posedge clk); #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
